mem_copy_engine: RTL



---
 rtl/mem_copy_engine.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : Block-copy initiator for an 8-bit memory with one
//                synchronous write port and one combinational read port.
//                A start command copies `length` cells from src_address to
//                dst_address, one cell per clock. Copies are overlap-safe
//                (memmove semantics), and all address arithmetic wraps
//                modulo 2^ADDR_WIDTH.
//
//  Ports       :
//    clock             in   system clock, rising-edge
//    reset             in   asynchronous, active-low reset
//    start             in   copy request, sampled only when idle
//    src_address       in   first source cell
//    dst_address       in   first destination cell
//    length            in   cells to copy (0 = no transfer)
//    busy              out  high from the cycle after start until done
//    done              out  one-cycle completion pulse
//    checksum          out  mod-2^DATA_WIDTH sum of the copied cells
//    mem_read_address  out  memory read address
//    mem_write_address out  memory write address
//    mem_write_data    out  memory write data (= mem_read_data)
//    mem_write_enable  out  memory write enable
//    mem_read_data     in   memory read data (combinational)
//
//  Build option: define MEM_COPY_CHECKSUM_EN to enable the running
//                checksum; otherwise checksum is tied to zero.
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_address,
  input  logic [ADDR_WIDTH-1:0] dst_address,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_COPY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_backward;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic                  r_we;

  logic [ADDR_WIDTH-1:0] w_delta;
  logic                  w_backward;
  logic [ADDR_WIDTH-1:0] w_len_m1;
  logic [ADDR_WIDTH-1:0] w_rd_first;
  logic [ADDR_WIDTH-1:0] w_wr_first;
  logic                  w_accept;

  // A destination that lies strictly inside the source window (ahead of
  // src by less than length) would be clobbered by a forward walk, so such
  // copies run from the top cell down. d == 0 copies in place, forward.
  assign w_delta    = dst_address - src_address;
  assign w_backward = (w_delta != c_ADDR_ZERO) && (w_delta < length);
  assign w_len_m1   = length - c_ADDR_ONE;
  assign w_rd_first = w_backward ? (src_address + w_len_m1) : src_address;
  assign w_wr_first = w_backward ? (dst_address + w_len_m1) : dst_address;
  assign w_accept   = (r_state == c_IDLE) && start;

  // Write data is the read port looped straight back: the engine never
  // holds the byte in flight.
  assign mem_write_data    = mem_read_data;
  assign busy              = r_busy;
  assign done              = r_done;
  assign mem_read_address  = r_rd_addr;
  assign mem_write_address = r_wr_addr;
  assign mem_write_enable  = r_we;

  // The memory-facing outputs are registered, so each step is issued one
  // cycle after the FSM decides it. The first COPY cycle after acceptance
  // therefore carries no write; it is the slot in which step 0 is
  // registered. A zero-length copy passes through that slot with nothing
  // to issue and goes straight on to DONE, which keeps its done timing one
  // cycle after the accepting edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_len      <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_backward <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_we       <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_done <= 1'b0;
          r_we   <= 1'b0;
          if (start) begin
            r_len      <= length;
            r_count    <= '0;
            r_rd_ptr   <= w_rd_first;
            r_wr_ptr   <= w_wr_first;
            r_backward <= w_backward;
            r_busy     <= 1'b1;
            r_state    <= c_COPY;
          end
        end

        c_COPY: begin
          if (r_count == r_len) begin
            // Every step has been issued; the last write commits at this
            // edge, so completion is reported in the following cycle.
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= c_DONE;
          end else begin
            r_rd_addr <= r_rd_ptr;
            r_wr_addr <= r_wr_ptr;
            r_we      <= 1'b1;
            r_count   <= r_count + c_ADDR_ONE;
            if (r_backward) begin
              r_rd_ptr <= r_rd_ptr - c_ADDR_ONE;
              r_wr_ptr <= r_wr_ptr - c_ADDR_ONE;
            end else begin
              r_rd_ptr <= r_rd_ptr + c_ADDR_ONE;
              r_wr_ptr <= r_wr_ptr + c_ADDR_ONE;
            end
          end
        end

        c_DONE: begin
          // The done cycle ignores start; a new request is taken in the
          // IDLE cycle that follows.
          r_done  <= 1'b0;
          r_we    <= 1'b0;
          r_state <= c_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_we    <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Accumulates on the same edges that commit writes, so it sums exactly
  // the bytes that land in the destination and is complete when done rises.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (r_we) begin
      r_checksum <= r_checksum + mem_read_data;
    end
  end

  assign checksum = r_checksum;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
  assign checksum        = '0;
`endif

endmodule
`default_nettype wire
